// File: rtl/sigmoid_seq_ctrl_pkg.sv
// rtl/sigmoid_seq_ctrl_pkg.sv - shared state encoding, 1.7.24 constants and width defaults
package sigmoid_seq_ctrl_pkg;

    localparam int SIG_DATA_W = 32;
    localparam int SIG_ADDR_W = 5;

    localparam int          FX_FRAC_W = 24;
    localparam logic [31:0] FX_ONE    = 32'h0100_0000;
    localparam logic [31:0] FX_HALF   = 32'h0080_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE,
        ST_DONE
    } ctrl_state_t;

endpackage

// File: rtl/sigmoid_ctrl_wdog.sv
// rtl/sigmoid_ctrl_wdog.sv - WAIT-cycle watchdog, built only with SIGMOID_CTRL_TIMEOUT_EN
`ifdef SIGMOID_CTRL_TIMEOUT_EN
module sigmoid_ctrl_wdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(LIMIT) + 1;

    logic [CW-1:0] cnt;

    // cnt holds the number of WAIT cycles already elapsed; expire flags the LIMIT-th one
    assign expire = run && (cnt == CW'(LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expire) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/sigmoid_seq_ctrl.sv
// rtl/sigmoid_seq_ctrl.sv - streams a vector through the shared sigmoid unit; watchdog via SIGMOID_CTRL_TIMEOUT_EN
module sigmoid_seq_ctrl
    import sigmoid_seq_ctrl_pkg::*;
#(
    parameter int DATA_W      = SIG_DATA_W,
    parameter int ADDR_W      = SIG_ADDR_W,
    parameter int MAX_LEN     = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   vec_len,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              act_en,
    output logic [DATA_W-1:0] act_data,
    output logic [ADDR_W-1:0] act_addr,
    input  logic [DATA_W-1:0] act_out_data,
    input  logic [ADDR_W-1:0] act_out_addr,
    input  logic              act_out_valid,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              tag_err,
    output logic              timeout
);

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

    ctrl_state_t     state;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] len_clamped;
    logic [ADDR_W:0] idx_next;
    logic            wd_expire;

    assign len_clamped = (vec_len > LEN_MAX) ? LEN_MAX : vec_len;
    assign idx_next    = idx + IDX_ONE;
    assign busy        = (state != ST_IDLE);

`ifdef SIGMOID_CTRL_TIMEOUT_EN
    sigmoid_ctrl_wdog #(
        .LIMIT (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == ST_ISSUE),
        .run    (state == ST_WAIT),
        .expire (wd_expire)
    );
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_CYC;
    assign wd_expire          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            len_q    <= '0;
            done     <= 1'b0;
            rd_en    <= 1'b0;
            rd_addr  <= '0;
            act_en   <= 1'b0;
            act_data <= '0;
            act_addr <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            tag_err  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            // strobes are single-cycle pulses; dropping them here is also how abort kills a pending write
            done   <= 1'b0;
            rd_en  <= 1'b0;
            act_en <= 1'b0;
            wr_en  <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            if (len_clamped == '0) begin
                                done  <= 1'b1;
                                state <= ST_DONE;
                            end else begin
                                len_q   <= len_clamped;
                                idx     <= '0;
                                tag_err <= 1'b0;
                                timeout <= 1'b0;
                                rd_en   <= 1'b1;
                                rd_addr <= '0;
                                state   <= ST_READ;
                            end
                        end
                    end
                    ST_READ: begin
                        state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        // operand and tag stay put until the result returns; the unit samples the tag late
                        act_data <= rd_data;
                        act_addr <= idx[ADDR_W-1:0];
                        act_en   <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (act_out_valid) begin
                            if (act_out_addr != idx[ADDR_W-1:0]) begin
                                tag_err <= 1'b1;
                            end
                            wr_en   <= 1'b1;
                            wr_addr <= idx[ADDR_W-1:0];
                            wr_data <= act_out_data;
                            state   <= ST_WRITE;
                        end else if (wd_expire) begin
                            timeout <= 1'b1;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end
                    ST_WRITE: begin
                        if (idx == len_q - IDX_ONE) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            idx     <= idx_next;
                            rd_en   <= 1'b1;
                            rd_addr <= idx_next[ADDR_W-1:0];
                            state   <= ST_READ;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sigmoid_seq_ctrl.sv
// tb/tb_sigmoid_seq_ctrl.sv - scoreboard bench for sigmoid_seq_ctrl; watchdog case under SIGMOID_CTRL_TIMEOUT_EN
module tb_sigmoid_seq_ctrl;
    import sigmoid_seq_ctrl_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW:0]   vec_len = '0;
    logic          busy, done, rd_en, act_en, wr_en, tag_err, timeout;
    logic [AW-1:0] rd_addr, act_addr, wr_addr, act_out_addr;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] act_data, wr_data, act_out_data;
    logic          act_out_valid;

    always #5 clk = ~clk;

    sigmoid_seq_ctrl #(
        .DATA_W (DW), .ADDR_W (AW), .MAX_LEN (32), .TIMEOUT_CYC (16)
    ) dut (
        .clk (clk), .rst_n (rst_n), .start (start), .abort (abort), .vec_len (vec_len),
        .busy (busy), .done (done), .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
        .act_en (act_en), .act_data (act_data), .act_addr (act_addr),
        .act_out_data (act_out_data), .act_out_addr (act_out_addr), .act_out_valid (act_out_valid),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data),
        .tag_err (tag_err), .timeout (timeout)
    );

    // hard sigmoid: 0.5 + x/4 clamped to [0, 1]
    function automatic logic [31:0] hsig(input logic [31:0] x);
        logic signed [31:0] y;
        y = $signed(FX_HALF) + ($signed(x) >>> 2);
        if (y < 0) return 32'h0;
        if (y > $signed(FX_ONE)) return FX_ONE;
        return y;
    endfunction

    logic [DW-1:0] src [32];
    logic [3:0]    pipe;
    bit            mute_valid = 1'b0;
    int            corrupt_idx = -1;

    always @(posedge clk) if (rd_en) rd_data <= src[rd_addr];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe <= '0;
        else        pipe <= {pipe[2:0], act_en};
    end
    assign act_out_valid = pipe[3] && !mute_valid;
    assign act_out_data  = hsig(act_data);
    assign act_out_addr  = (int'(act_addr) == corrupt_idx) ? (act_addr ^ 5'd1) : act_addr;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    wr_t sb [$];

    int vectors = 0, miscompares = 0;
    int cyc = 0, start_cyc = 0;
    int n_rd = 0, n_act = 0, n_wr = 0, n_done = 0, last_done_cyc = -1, last_wr_addr = -1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) n_rd++;
            if (act_en) n_act++;
            if (rd_en || act_en || wr_en)
                check("strobe_excl", 64'(int'(rd_en) + int'(act_en) + int'(wr_en)), 64'd1);
            if (wr_en) begin
                wr_t e;
                n_wr++;
                last_wr_addr = int'(wr_addr);
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.a));
                    check("wr_data", 64'(wr_data), 64'(e.d));
                end
            end
            if (done) begin
                n_done++;
                last_done_cyc = cyc - start_cyc;
            end
        end
    end

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) sb.push_back('{a: AW'(i), d: hsig(src[i])});
    endtask

    task automatic launch(input int len);
        n_rd = 0; n_act = 0; n_wr = 0; n_done = 0; last_done_cyc = -1; last_wr_addr = -1;
        vec_len   = (AW + 1)'(len);
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) @(posedge clk);
        #1;
        check("done_seen", 64'(n_done), 64'd1);
    endtask

    task automatic run_vec(input int len, input int elems, input int done_at);
        push_exp(elems);
        launch(len);
        wait_done(8 * elems + 20);
        check("done_cycle", 64'(last_done_cyc), 64'(done_at));
        check("rd_count", 64'(n_rd), 64'(elems));
        check("act_count", 64'(n_act), 64'(elems));
        check("wr_count", 64'(n_wr), 64'(elems));
        check("sb_drained", 64'(sb.size()), 64'd0);
        check("busy_after", 64'(busy), 64'd0);
        if (elems > 0) check("last_wr_addr", 64'(last_wr_addr), 64'(elems - 1));
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {busy, done, rd_en, act_en, wr_en, tag_err, timeout, rd_addr, act_addr, wr_addr},
              64'd0);
        check({tag, "_data"}, {act_data, wr_data}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) src[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;

        run_vec(4, 4, 33);

        for (int i = 0; i < 32; i++) src[i] = 32'(i * 32'h0040_0000) - 32'h0400_0000;
        run_vec(32, 32, 257);

        run_vec(0, 0, 1);

        for (int i = 0; i < 32; i++) src[i] = $urandom;
        run_vec(40, 32, 257);

        corrupt_idx = 2;
        run_vec(3, 3, 25);
        corrupt_idx = -1;
        check("tag_err_set", 64'(tag_err), 64'd1);
        repeat (3) @(posedge clk); #1;
        check("tag_err_sticky", 64'(tag_err), 64'd1);

        corrupt_idx = 0;
        push_exp(1);
        launch(4);
        repeat (12) @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("abort_idle", 64'(busy), 64'd0);
        check("abort_keeps_tag_err", 64'(tag_err), 64'd1);
        repeat (20) @(posedge clk); #1;
        check("abort_wr_count", 64'(n_wr), 64'd1);
        check("abort_no_done", 64'(n_done), 64'd0);
        check("abort_sb", 64'(sb.size()), 64'd0);
        corrupt_idx = -1;

        run_vec(4, 4, 33);
        check("tag_err_cleared", 64'(tag_err), 64'd0);

`ifdef SIGMOID_CTRL_TIMEOUT_EN
        mute_valid = 1'b1;
        launch(3);
        wait_done(40);
        check("to_done_cycle", 64'(last_done_cyc), 64'd20);
        check("to_flag", 64'(timeout), 64'd1);
        check("to_wr_count", 64'(n_wr), 64'd0);
        check("to_act_count", 64'(n_act), 64'd1);
        mute_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
`else
        check("timeout_tied", 64'(timeout), 64'd0);
`endif

        push_exp(4);
        launch(4);
        repeat (9) @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrun_reset");
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk); #1;
        check("midrun_no_done", 64'(n_done), 64'd0);
        check("midrun_idle", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sigmoid_seq_ctrl.md
Name: sigmoid_seq_ctrl

Overview:
Sequencer that streams a vector of up to 32 fixed-point (1.7.24) elements from a source buffer through the shared single-element sigmoid unit, then writes the results to a destination buffer. It sits between the layer controller (start/done) and the sigmoid unit plus its two scratch buffers. It owns element indexing, the sigmoid unit's enable/operand handshake and result write-back. One element is in flight at a time.

Parameters:
DATA_W, 32, element width (1.7.24 fixed point)
ADDR_W, 5, buffer address width
MAX_LEN, 32, maximum vector length; must equal 2**ADDR_W
TIMEOUT_CYC, 16, watchdog limit in WAIT cycles (used only with the optional feature)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin vector; sampled only in IDLE
abort  in  1  synchronous abort; forces IDLE next cycle
vec_len  in  6  element count, 0..32; values above 32 are clamped to 32
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of vector
rd_en  out  1  source buffer read strobe
rd_addr  out  ADDR_W  source address
rd_data  in  DATA_W  source data, valid 1 cycle after rd_en
act_en  out  1  one-cycle enable pulse to sigmoid unit
act_data  out  DATA_W  operand to sigmoid unit
act_addr  out  ADDR_W  element tag to sigmoid unit
act_out_data  in  DATA_W  sigmoid result
act_out_addr  in  ADDR_W  returned tag
act_out_valid  in  1  result valid, one-cycle pulse
wr_en  out  1  destination write strobe
wr_addr  out  ADDR_W  destination address
wr_data  out  DATA_W  destination data
tag_err  out  1  sticky: returned tag differed from issued index
timeout  out  1  sticky watchdog flag (0 without optional feature)

Behaviour:
- Reset: all outputs 0, state IDLE, index 0, sticky flags cleared. Reset mid-vector discards all progress. No partial done is issued.
- States: IDLE, READ, LOAD, ISSUE, WAIT, WRITE, DONE.
- IDLE:
  - start=1 with clamped len>0: latch len, clear index and sticky flags, go to READ.
  - start=1 with len=0: go directly to DONE. No rd/act/wr traffic.
  - start while busy is ignored.
- READ: rd_en=1, rd_addr=index, go to LOAD.
- LOAD: capture rd_data into the operand register, go to ISSUE.
- ISSUE: act_en=1 for exactly one cycle, go to WAIT.
- act_data and act_addr (=index) are registered. They hold stable from ISSUE until act_out_valid is seen, because the sigmoid unit samples its tag late.
- WAIT: stay until act_out_valid=1. Then capture act_out_data. If act_out_addr≠index, set tag_err. Go to WRITE.
- WRITE:
  - wr_en=1, wr_addr=index (issued index, not the returned tag), wr_data=captured result.
  - If index==len-1, go to DONE. Otherwise index+1 and go to READ.
- DONE: done=1 for one cycle, go to IDLE.
- Latency: 8 cycles per element with the in-house sigmoid unit (WAIT lasts 4 cycles). For start sampled in cycle 0, done is high in cycle 8N+1.
- Index is ADDR_W+1 bits wide internally, so len=32 terminates correctly without wrap-around.
- abort has priority over every transition. It forces IDLE next cycle, gives no done, suppresses any pending wr_en, and leaves sticky flags intact.
- act_out_valid arriving outside WAIT is ignored.
- rd_en, act_en and wr_en are never high in the same cycle.

Optional Feature:
SIGMOID_CTRL_TIMEOUT_EN
- Defined: a WAIT cycle counter resets on entry to WAIT. When it reaches TIMEOUT_CYC without act_out_valid, the block sets timeout, skips WRITE for that element and the remaining elements, and goes to DONE (done still pulses).
- Undefined: WAIT waits indefinitely, and timeout is tied to 0.

Decomposition:
- Shared package holds:
  - state encoding constants;
  - 1.7.24 format constants (ONE = 0x01000000);
  - DATA_W/ADDR_W defaults shared with the sigmoid unit.
- No sub-module needed. If the optional watchdog is enabled, it is a natural small sub-module: sigmoid_ctrl_wdog (counter, clear, expire).

Test Plan:
- Reset then start, len=4, src[i]=0x00000000 with the real sigmoid unit: 4 writes to addr 0..3 with the model's sigmoid(0) value, done in cycle 33, busy low after.
- start, len=32: 32 writes, last wr_addr=31, done in cycle 257. Index does not wrap to a 33rd read.
- start, len=0: done in cycle 1, no rd_en, act_en or wr_en. len=40: exactly 32 elements processed.
- Stub unit returns act_out_addr=index^1 on element 2 of len=3: tag_err=1 sticky, write still goes to addr 2, done issued.
- abort asserted during WAIT of element 1 (len=4): IDLE next cycle, no further wr_en, no done. A fresh start then runs normally.
- With SIGMOID_CTRL_TIMEOUT_EN, TIMEOUT_CYC=16, stub unit never returns valid: timeout=1 after 16 WAIT cycles, done pulses, zero writes. rst_n low mid-run clears all outputs.
